fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 25 ++
 rtl/uart_baud_counter.sv | 29 ++
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int DATA_BITS    = 8;
  localparam int BYTES_SENT_W = 16;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running 0..CLKS_PER_BIT-1 bit-period counter; bit_end on the last cycle of a bit,
// bit_pre_end one cycle earlier so registered outputs can line up with bit_end.
module uart_baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int W = clog2_min1(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || count == LAST) count <= '0;
    else                                 count <= count + W'(1);
  end

  assign bit_end     = (count == LAST);
  assign bit_pre_end = (count == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from an FWFT FIFO and sends it as 8N1/8N2 UART; FIFO_UART_TX_PARITY_EN adds a parity bit.
// Start bit 1 cycle after the pop; ena only gates new frames, a frame in flight always completes.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic [DATA_BITS-1:0]    fifo_data,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done,
  output logic [BYTES_SENT_W-1:0] bytes_sent
);

  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx;
  logic                 bit_end;
  logic                 bit_pre_end;
  logic                 baud_clear;
  logic                 stop_last;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic parity_q;
`endif

  // The pre-frame states hold the counter at zero so START begins a full bit period.
  assign baud_clear = (state == ST_IDLE) || (state == ST_SETTLE) || (state == ST_LOAD);
  assign stop_last  = (bit_idx == STOP_LAST);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear      (baud_clear),
    .bit_end    (bit_end),
    .bit_pre_end(bit_pre_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_q    <= '0;
      bit_idx    <= '0;
      fifo_rd    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      bytes_sent <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (ena && !fifo_empty) begin
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          state   <= ST_LOAD;
          fifo_rd <= 1'b1;
        end
        ST_LOAD: begin
          shift_q <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q <= (^fifo_data) ^ PAR_SENSE;
`endif
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= ST_START;
        end
        ST_START: begin
          if (bit_end) begin
            tx      <= shift_q[0];
            shift_q <= shift_q >> 1;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity_q;
              state   <= ST_PARITY;
`else
              tx      <= 1'b1;
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Raised a cycle early so the registered pulse lands on the final stop cycle.
          if (bit_pre_end && stop_last) begin
            tx_done    <= 1'b1;
            bytes_sent <= bytes_sent + 16'd1;
          end
          if (bit_end) begin
            if (stop_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (1 and 2 stop bits) fed from queue-backed FWFT FIFOs, checked every cycle against a frame-timing model.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst = 2'b11;
  logic [1:0]  ena = 2'b00;
  logic [1:0]  fempty = 2'b11;
  logic [1:0]  frd, tx, busy, done;
  logic [7:0]  fdat [2];
  logic [7:0]  hprev [2];
  logic [15:0] bsent [2];
  logic [7:0]  fq0 [$];
  logic [7:0]  fq1 [$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0)) dut_s1 (
    .clk(clk), .reset(rst[0]), .ena(ena[0]), .fifo_data(fdat[0]), .fifo_empty(fempty[0]),
    .fifo_rd(frd[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]), .bytes_sent(bsent[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(1)) dut_s2 (
    .clk(clk), .reset(rst[1]), .ena(ena[1]), .fifo_data(fdat[1]), .fifo_empty(fempty[1]),
    .fifo_rd(frd[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]), .bytes_sent(bsent[1]));

  function automatic int qsize(input int l);
    return (l == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic logic [7:0] qfront(input int l);
    if (qsize(l) == 0) return 8'h00;
    return (l == 0) ? fq0[0] : fq1[0];
  endfunction

  task automatic push(input int l, input logic [7:0] b);
    if (l == 0) fq0.push_back(b);
    else        fq1.push_back(b);
  endtask

  // FWFT FIFO: empty tracks the queue, data follows one cycle later.
  initial begin
    fdat[0] = 8'h00; fdat[1] = 8'h00; hprev[0] = 8'h00; hprev[1] = 8'h00;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frd[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (frd[1] && fq1.size() > 0) void'(fq1.pop_front());
    fempty[0] <= (fq0.size() == 0);
    fempty[1] <= (fq1.size() == 0);
    fdat[0]   <= hprev[0];
    fdat[1]   <= hprev[1];
    hprev[0]  <= qfront(0);
    hprev[1]  <= qfront(1);
  end

  // Reference model: a frame is described by its pop cycle T and its byte.
  bit         m_valid [2] = '{0, 0};
  bit         m_act   [2] = '{0, 0};
  int         m_T     [2];
  int         m_end   [2];
  int         m_cnt   [2] = '{0, 0};
  logic [7:0] m_byte  [2];
  bit         was_idle;

  function automatic int flen(input int l);
    return (9 + (l + 1) + P) * C;
  endfunction

  function automatic logic exp_tx(input int l, input int n);
    int k, b;
    if (!m_act[l]) return 1'b1;
    k = n - m_T[l];
    if (k < 1) return 1'b1;
    b = (k - 1) / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[l][b-1];
    if (P == 1 && b == 9) return (^m_byte[l]) ^ (l == 1);
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int l, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane %0d cycle %0d: got %0d expected %0d", nm, l, cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (m_act[l] && cyc == m_end[l]) m_cnt[l]++;
      if (m_valid[l]) begin
        chk("fifo_rd",    l, int'(frd[l]),  int'(m_act[l] && cyc == m_T[l]));
        chk("tx",         l, int'(tx[l]),   int'(exp_tx(l, cyc)));
        chk("busy",       l, int'(busy[l]), int'(m_act[l]));
        chk("tx_done",    l, int'(done[l]), int'(m_act[l] && cyc == m_end[l]));
        chk("bytes_sent", l, int'(bsent[l]), m_cnt[l] & 16'hFFFF);
      end
      was_idle = !m_act[l];
      if (m_act[l] && cyc == m_end[l]) m_act[l] = 1'b0;
      if (rst[l]) begin
        m_act[l]   = 1'b0;
        m_cnt[l]   = 0;
        m_valid[l] = 1'b1;
      end else if (m_valid[l] && was_idle && ena[l] && !fempty[l]) begin
        m_act[l]  = 1'b1;
        m_T[l]    = cyc + 2;
        m_end[l]  = cyc + 2 + flen(l);
        m_byte[l] = qfront(l);
      end
    end
  end

  // which: 0 = empty fell, 1 = fifo_rd, 2 = tx_done
  task automatic wait_ev(input int l, input int which, input int budget, input string nm, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && !fempty[l]) || (which == 1 && frd[l]) || (which == 2 && done[l])) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: lane %0d no event within %0d cycles", nm, l, budget);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, t, r1, r2, run, cnt, lows;
    logic [9:0] a5_lv;
    a5_lv = (P == 1) ? 10'b0101001010 : 10'b1101001010;

    repeat (3) drive_edge();
    rst = 2'b00;
    ena = 2'b11;
    repeat (2) drive_edge();
    @(negedge clk);
    lit("reset_tx", int'(tx[0]), 1);
    lit("reset_busy", int'(busy[0]), 0);
    lit("reset_bytes_sent", int'(bsent[0]), 0);
    lit("reset_fifo_rd", int'(frd[0]), 0);

    // Single 0xA5 frame on the 1-stop lane.
    drive_edge();
    push(0, 8'hA5);
    wait_ev(0, 0, 10, "a5_empty", c0);
    wait_ev(0, 1, 10, "a5_rd", t);
    lit("a5_rd_cycle", t - c0, 2);
    for (int j = 0; j < 10; j++) begin
      while (cyc < c0 + 3 + 4 * j + 1) @(negedge clk);
      lit($sformatf("a5_level%0d", j), int'(tx[0]), int'(a5_lv[j]));
    end
    wait_ev(0, 2, 20, "a5_done", t);
    lit("a5_done_cycle", t - c0, 42 + 4 * P);
    @(negedge clk);
    lit("a5_bytes_sent", int'(bsent[0]), 1);

    // Back-to-back 0x00, 0xFF.
    drive_edge();
    push(0, 8'h00);
    push(0, 8'hFF);
    wait_ev(0, 1, 20, "b2b_rd1", r1);
    wait_ev(0, 1, 100, "b2b_rd2", r2);
    lit("b2b_period", r2 - r1, 43 + 4 * P);
    wait_ev(0, 2, 100, "b2b_done", t);
    @(negedge clk);
    lit("b2b_bytes_sent", int'(bsent[0]), 3);

    // Two stop bits, 0x3C.
    drive_edge();
    push(1, 8'h3C);
    wait_ev(1, 0, 10, "s2_empty", c0);
    run = 0;
    t = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      run = tx[1] ? run + 1 : 0;
      if (done[1]) begin
        t = cyc;
        break;
      end
    end
    lit("s2_done_cycle", t - c0, 46 + 4 * P);
    lit("s2_high_run", run, 8 + 4 * P);

    // ena low with data waiting: nothing may happen.
    drive_edge();
    ena[0] = 1'b0;
    push(0, 8'h55);
    cnt = 0;
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(frd[0]);
      lows += int'(!tx[0]);
    end
    lit("ena0_pops", cnt, 0);
    lit("ena0_tx_low_cycles", lows, 0);

    // ena dropped mid-frame: frame finishes, no further pops.
    drive_edge();
    ena[0] = 1'b1;
    wait_ev(0, 1, 10, "midena_rd", t);
    repeat (5) drive_edge();
    ena[0] = 1'b0;
    push(0, 8'hAA);
    wait_ev(0, 2, 100, "midena_done", t);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      cnt += int'(frd[0]);
    end
    lit("midena_pops_after", cnt, 0);
    lit("midena_queue_left", qsize(0), 1);
    drive_edge();
    ena[0] = 1'b1;
    wait_ev(0, 2, 100, "midena_drain", t);

    // Reset during data bit 3.
    drive_edge();
    push(0, 8'h5A);
    wait_ev(0, 1, 10, "rst_rd", t);
    while (cyc < t + 17) @(negedge clk);
    lit("pre_reset_bytes_sent", int'(bsent[0]), 5);
    drive_edge();
    rst[0] = 1'b1;
    drive_edge();
    rst[0] = 1'b0;
    @(negedge clk);
    lit("post_reset_tx", int'(tx[0]), 1);
    lit("post_reset_busy", int'(busy[0]), 0);
    lit("post_reset_done", int'(done[0]), 0);
    lit("post_reset_bytes_sent", int'(bsent[0]), 0);

`ifdef FIFO_UART_TX_PARITY_EN
    drive_edge();
    push(0, 8'h07);
    wait_ev(0, 0, 10, "par_even_empty", c0);
    while (cyc < c0 + 40) @(negedge clk);
    lit("parity_even_07", int'(tx[0]), 1);
    wait_ev(0, 2, 20, "par_even_done", t);
    drive_edge();
    push(1, 8'h07);
    wait_ev(1, 0, 10, "par_odd_empty", c0);
    while (cyc < c0 + 40) @(negedge clk);
    lit("parity_odd_07", int'(tx[1]), 0);
    wait_ev(1, 2, 30, "par_odd_done", t);
    drive_edge();
    push(0, 8'h07);
    push(0, 8'h07);
    wait_ev(0, 1, 20, "par_b2b_rd1", r1);
    wait_ev(0, 1, 100, "par_b2b_rd2", r2);
    lit("parity_b2b_period", r2 - r1, 47);
    wait_ev(0, 2, 100, "par_b2b_done", t);
`endif

    // Random traffic with ena toggling and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_edge();
      for (int l = 0; l < 2; l++) begin
        if ($urandom_range(0, 19) == 0 && qsize(l) < 4) push(l, 8'($urandom));
        if ($urandom_range(0, 59) == 0) ena[l] = ~ena[l];
        rst[l] = ($urandom_range(0, 699) == 0);
      end
    end
    drive_edge();
    rst = 2'b00;
    ena = 2'b11;
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (qsize(0) == 0 && qsize(1) == 0 && !busy[0] && !busy[1]) begin
        t = cyc;
        break;
      end
    end
    lit("random_drain_completed", int'(t >= 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
